// File: rtl/pacman_pkg.sv
// Shared maze-game types and constants.
// Grid geometry, pellet FSM states, field init.
package pacman_pkg;

  localparam int GRID_DIM     = 16;
  localparam int COORD_W      = 4;
  localparam int PELLET_TOTAL = 255;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } pellet_state_t;

  function automatic logic [GRID_DIM-1:0] init_row(
    input logic [COORD_W-1:0] row,
    input int                 sx,
    input int                 sy
  );
    logic [GRID_DIM-1:0] r;
    r = '1;
    if (int'(row) == sy) r[sx] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pellet_tracker_if.sv
// Game-side bundle for the pellet tracker.
// Master drives positions/queries, slave reports.
interface pellet_tracker_if
  import pacman_pkg::*;
#(
  parameter int SCORE_W = 8
);

  logic               game_active;
  logic               restart_i;
  logic [COORD_W-1:0] pacman_x;
  logic [COORD_W-1:0] pacman_y;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               rd_pellet;
  logic [SCORE_W-1:0] score;
  logic [8:0]         pellets_left;
  logic               busy;
  logic               level_clear;

  modport master (
    output game_active, restart_i,
    output pacman_x, pacman_y, rd_x, rd_y,
    input  rd_pellet, score, pellets_left,
    input  busy, level_clear
  );

  modport slave (
    input  game_active, restart_i,
    input  pacman_x, pacman_y, rd_x, rd_y,
    output rd_pellet, score, pellets_left,
    output busy, level_clear
  );

endinterface

// File: rtl/pellet_bitmap.sv
// 16x16 pellet storage: row load, bit clear,
// eat probe and registered renderer read.
module pellet_bitmap
  import pacman_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [COORD_W-1:0]  wr_row,
  input  logic [GRID_DIM-1:0] wr_data,
  input  logic                clr_en,
  input  logic [COORD_W-1:0]  clr_x,
  input  logic [COORD_W-1:0]  clr_y,
  input  logic [COORD_W-1:0]  pr_x,
  input  logic [COORD_W-1:0]  pr_y,
  output logic                pr_bit,
  input  logic                rd_block,
  input  logic [COORD_W-1:0]  rd_x,
  input  logic [COORD_W-1:0]  rd_y,
  output logic                rd_bit
);

  logic [GRID_DIM-1:0] rows [GRID_DIM];
  logic                clr_hit;

  assign pr_bit  = rows[pr_y][pr_x];
  assign clr_hit = clr_en && (clr_x == rd_x) && (clr_y == rd_y);

  // Field storage: sweep writes whole rows, eats clear one bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < GRID_DIM; i++) rows[i] <= '0;
    end else begin
      if (wr_en)  rows[wr_row] <= wr_data;
      if (clr_en) rows[clr_y][clr_x] <= 1'b0;
    end
  end

  // Renderer read; a bit being cleared this edge already reads empty.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_bit <= 1'b0;
    else        rd_bit <= !rd_block && rows[rd_y][rd_x] && !clr_hit;
  end

endmodule

// File: rtl/pellet_tracker.sv
// Pellet field tracker: load sweep, eating,
// saturating score and level-clear pulse.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int SCORE_W    = 8,
  parameter int PELLET_PTS = 1,
  parameter int START_X    = 0,
  parameter int START_Y    = 0
) (
  input  logic             clk_i,
  input  logic             reset,
  pellet_tracker_if.slave  bus
);

  localparam logic [SCORE_W:0] PTS = (SCORE_W+1)'(PELLET_PTS);
  localparam logic [SCORE_W:0] MAX = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [8:0]       FULL = 9'(PELLET_TOTAL);

  pellet_state_t      state, state_n;
  logic [COORD_W-1:0] ld_row;
  logic [SCORE_W-1:0] score;
  logic [8:0]         pellets_left;
  logic               level_clear, clear_n;
  logic               eat, pr_bit;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] score_n;

  pellet_bitmap u_bitmap (
    .clk      (clk_i),
    .rst_n    (reset),
    .wr_en    (state == LOAD),
    .wr_row   (ld_row),
    .wr_data  (init_row(ld_row, START_X, START_Y)),
    .clr_en   (eat),
    .clr_x    (bus.pacman_x),
    .clr_y    (bus.pacman_y),
    .pr_x     (bus.pacman_x),
    .pr_y     (bus.pacman_y),
    .pr_bit   (pr_bit),
    .rd_block (state == LOAD),
    .rd_x     (bus.rd_x),
    .rd_y     (bus.rd_y),
    .rd_bit   (bus.rd_pellet)
  );

  assign sum     = {1'b0, score} + PTS;
  assign score_n = (sum > MAX) ? '1 : sum[SCORE_W-1:0];

  // Next state and eat decision; restart overrides everything.
  always_comb begin
    state_n = state;
    eat     = 1'b0;
    clear_n = 1'b0;
    unique case (state)
      LOAD: if (ld_row == COORD_W'(GRID_DIM-1)) state_n = RUN;
      RUN: begin
        if (bus.game_active && pr_bit) begin
          eat = 1'b1;
          if (pellets_left == 9'd1) begin
            state_n = DONE;
            clear_n = 1'b1;
          end
        end
      end
      DONE: state_n = DONE;
      default: state_n = LOAD;
    endcase
    if (bus.restart_i) begin
      state_n = LOAD;
      eat     = 1'b0;
      clear_n = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset) state <= LOAD;
    else        state <= state_n;
  end

  // Sweep counter, score, remaining count and clear pulse.
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      ld_row       <= '0;
      score        <= '0;
      pellets_left <= FULL;
      level_clear  <= 1'b0;
    end else begin
      level_clear <= clear_n;
      if (bus.restart_i) begin
        ld_row       <= '0;
        pellets_left <= FULL;
      end else begin
        if (state == LOAD) ld_row <= ld_row + COORD_W'(1);
        if (eat) begin
          score        <= score_n;
          pellets_left <= pellets_left - 9'd1;
        end
      end
    end
  end

  assign bus.score        = score;
  assign bus.pellets_left = pellets_left;
  assign bus.busy         = (state == LOAD);
  assign bus.level_clear  = level_clear;

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed bench for pellet_tracker.
// Scenario tasks with hand-computed expectations.
module tb_pellet_tracker;
  import pacman_pkg::*;

  logic clk_i = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pellet_tracker_if #(.SCORE_W(8)) bus ();

  pellet_tracker #(
    .SCORE_W    (8),
    .PELLET_PTS (1),
    .START_X    (0),
    .START_Y    (0)
  ) dut (
    .clk_i (clk_i),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic count_busy(input string nm);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      step();
      cnt++;
    end
    tests++;
    if (cnt !== 16) begin
      fails++;
      $display("FAIL %s busy cycles got %0d want 16", nm, cnt);
    end
  endtask

  task automatic test_reset();
    bus.game_active = 1'b1;
    bus.restart_i   = 1'b0;
    bus.pacman_x    = 4'd0;
    bus.pacman_y    = 4'd0;
    bus.rd_x        = 4'd0;
    bus.rd_y        = 4'd0;
    reset = 1'b0;
    step();
    step();
    tests++;
    if (bus.busy !== 1'b1 || bus.score !== 8'd0 ||
        bus.pellets_left !== 9'd255 || bus.rd_pellet !== 1'b0 ||
        bus.level_clear !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals busy=%b score=%0d left=%0d rd=%b lc=%b want 1 0 255 0 0",
               bus.busy, bus.score, bus.pellets_left, bus.rd_pellet,
               bus.level_clear);
    end
    reset = 1'b1;
    count_busy("reset_load");
    tests++;
    if (bus.pellets_left !== 9'd255 || bus.score !== 8'd0) begin
      fails++;
      $display("FAIL after_load left=%0d score=%0d want 255 0",
               bus.pellets_left, bus.score);
    end
    step();
    tests++;
    if (bus.rd_pellet !== 1'b0) begin
      fails++;
      $display("FAIL rd_start got %b want 0", bus.rd_pellet);
    end
    bus.rd_x = 4'd1;
    step();
    tests++;
    if (bus.rd_pellet !== 1'b1) begin
      fails++;
      $display("FAIL rd_1_0 got %b want 1", bus.rd_pellet);
    end
  endtask

  task automatic test_eat_hold();
    bus.pacman_x = 4'd1;
    bus.pacman_y = 4'd0;
    step();
    tests++;
    if (bus.score !== 8'd1 || bus.pellets_left !== 9'd254) begin
      fails++;
      $display("FAIL eat_once score=%0d left=%0d want 1 254",
               bus.score, bus.pellets_left);
    end
    for (int i = 0; i < 4; i++) step();
    tests++;
    if (bus.score !== 8'd1 || bus.pellets_left !== 9'd254) begin
      fails++;
      $display("FAIL eat_hold score=%0d left=%0d want 1 254",
               bus.score, bus.pellets_left);
    end
    bus.rd_x = 4'd1;
    bus.rd_y = 4'd0;
    step();
    tests++;
    if (bus.rd_pellet !== 1'b0) begin
      fails++;
      $display("FAIL rd_eaten got %b want 0", bus.rd_pellet);
    end
  endtask

  task automatic test_restart_collision();
    bus.pacman_x  = 4'd2;
    bus.pacman_y  = 4'd0;
    bus.restart_i = 1'b1;
    step();
    bus.restart_i   = 1'b0;
    bus.game_active = 1'b0;
    tests++;
    if (bus.score !== 8'd1 || bus.pellets_left !== 9'd255 ||
        bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_collide score=%0d left=%0d busy=%b want 1 255 1",
               bus.score, bus.pellets_left, bus.busy);
    end
    count_busy("collide_load");
  endtask

  task automatic test_inactive();
    for (int i = 0; i < 10; i++) step();
    tests++;
    if (bus.score !== 8'd1 || bus.pellets_left !== 9'd255) begin
      fails++;
      $display("FAIL inactive score=%0d left=%0d want 1 255",
               bus.score, bus.pellets_left);
    end
    bus.game_active = 1'b1;
    step();
    tests++;
    if (bus.score !== 8'd2 || bus.pellets_left !== 9'd254) begin
      fails++;
      $display("FAIL resume score=%0d left=%0d want 2 254",
               bus.score, bus.pellets_left);
    end
    step();
    tests++;
    if (bus.score !== 8'd2 || bus.pellets_left !== 9'd254) begin
      fails++;
      $display("FAIL resume_hold score=%0d left=%0d want 2 254",
               bus.score, bus.pellets_left);
    end
  endtask

  task automatic test_level_clear();
    int lc;
    lc = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        bus.pacman_x = 4'(x);
        bus.pacman_y = 4'(y);
        step();
        if (bus.level_clear === 1'b1) lc++;
      end
    end
    tests++;
    if (bus.level_clear !== 1'b1 || bus.pellets_left !== 9'd0 ||
        dut.state !== DONE) begin
      fails++;
      $display("FAIL final_eat lc=%b left=%0d state=%0d want 1 0 DONE",
               bus.level_clear, bus.pellets_left, dut.state);
    end
    tests++;
    if (bus.score !== 8'd255) begin
      fails++;
      $display("FAIL score_sat got %0d want 255", bus.score);
    end
    step();
    step();
    if (bus.level_clear === 1'b1) lc++;
    tests++;
    if (lc !== 1) begin
      fails++;
      $display("FAIL lc_pulses got %0d want 1", lc);
    end
    tests++;
    if (dut.state !== DONE || bus.pellets_left !== 9'd0) begin
      fails++;
      $display("FAIL done_hold state=%0d left=%0d want DONE 0",
               dut.state, bus.pellets_left);
    end
  endtask

  task automatic test_restart_saturate();
    bus.rd_x      = 4'd1;
    bus.rd_y      = 4'd0;
    bus.restart_i = 1'b1;
    step();
    bus.restart_i = 1'b0;
    step();
    step();
    tests++;
    if (bus.rd_pellet !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL rd_in_load rd=%b busy=%b want 0 1",
               bus.rd_pellet, bus.busy);
    end
    repeat (14) step();
    tests++;
    if (bus.busy !== 1'b0 || bus.pellets_left !== 9'd255 ||
        bus.score !== 8'd255) begin
      fails++;
      $display("FAIL reload busy=%b left=%0d score=%0d want 0 255 255",
               bus.busy, bus.pellets_left, bus.score);
    end
    step();
    tests++;
    if (bus.pellets_left !== 9'd254 || bus.score !== 8'd255) begin
      fails++;
      $display("FAIL sat_eat left=%0d score=%0d want 254 255",
               bus.pellets_left, bus.score);
    end
    step();
    tests++;
    if (bus.rd_pellet !== 1'b1) begin
      fails++;
      $display("FAIL rd_reloaded got %b want 1", bus.rd_pellet);
    end
  endtask

  task automatic test_mid_reset();
    reset         = 1'b0;
    bus.restart_i = 1'b1;
    step();
    reset         = 1'b1;
    bus.restart_i = 1'b0;
    tests++;
    if (bus.score !== 8'd0 || bus.pellets_left !== 9'd255 ||
        bus.busy !== 1'b1 || bus.rd_pellet !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset score=%0d left=%0d busy=%b rd=%b want 0 255 1 0",
               bus.score, bus.pellets_left, bus.busy, bus.rd_pellet);
    end
    count_busy("mid_reset_load");
  endtask

  initial begin
    test_reset();
    test_eat_hold();
    test_restart_collision();
    test_inactive();
    test_level_clear();
    test_restart_saturate();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
